// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_pkg
// Description : Shared types and widths for the I2C target: FSM state
//               encoding, bit-counter width and glitch-filter counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

    // Bit counter must reach 8 (read path counts driven bits 0..8).
    localparam int BIT_CNT_W  = 4;
    // Filter counter holds up to FILTER_LEN-1 with FILTER_LEN <= 15.
    localparam int FILT_CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        WR_BYTE  = 3'd3,
        WR_ACK   = 3'd4,
        RD_BYTE  = 3'd5,
        RD_ACK   = 3'd6,
        WAIT     = 3'd7
    } i2c_state_t;

endpackage : i2c_pkg
`default_nettype wire

// File: rtl/i2c_line_filter.sv
`default_nettype none
// ============================================================================
// Module      : i2c_line_filter
// Description : Conditions one raw I2C pad level: two-flop synchroniser,
//               then a counter that only lets the filtered level follow the
//               synchronised level after FILTER_LEN consecutive samples that
//               disagree with it. One-clk rise/fall pulses accompany each
//               change of the filtered level.
// Ports       : clk, reset_n (async, active-low; level resets to 1)
//               line_i  - raw pad level
//               level   - filtered level
//               rise    - one-clk pulse, first cycle level reads 1
//               fall    - one-clk pulse, first cycle level reads 0
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_line_filter
    import i2c_pkg::*;
#(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic line_i,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam logic [FILT_CNT_W-1:0] c_cnt_max = FILT_CNT_W'(FILTER_LEN - 1);

    logic [1:0]            r_sync;
    logic [FILT_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= 2'b11;
            r_cnt  <= '0;
            level  <= 1'b1;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], line_i};
            rise   <= 1'b0;
            fall   <= 1'b0;
            if (r_sync[1] == level) begin
                // Any agreeing sample restarts the run of disagreeing ones.
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_max) begin
                level <= r_sync[1];
                r_cnt <= '0;
                rise  <= r_sync[1];
                fall  <= ~r_sync[1];
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule : i2c_line_filter
`default_nettype wire

// File: rtl/i2c_target.sv
`default_nettype none
// ============================================================================
// Module      : i2c_target
// Description : I2C target (no clock stretching) bridging the two-wire bus
//               to a single-cycle 8-bit register port. First written byte
//               after the address sets the register pointer; further
//               written bytes are stored with auto-increment. Reads return
//               reg_rdata with auto-increment until the controller NACKs.
// Ports       : clk, reset_n (async, active-low)
//               scl_i, sda_i     - raw pad levels
//               sda_oe           - 1 pulls SDA low (open-drain)
//               reg_addr         - register pointer
//               reg_wdata/reg_we - write data and one-clk strobe
//               reg_re/reg_rdata - one-clk read strobe, data valid next clk
//               addressed        - high from address ACK to START/STOP
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = 7'h60,
    parameter int         FILTER_LEN  = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       addressed
);

    localparam logic [BIT_CNT_W-1:0] c_last_bit  = BIT_CNT_W'(7);
    localparam logic [BIT_CNT_W-1:0] c_byte_done = BIT_CNT_W'(8);

    logic w_scl_level, w_scl_rise, w_scl_fall;
    logic w_sda_level, w_sda_rise, w_sda_fall;
    logic w_start, w_stop;
    logic [7:0] w_byte;

    i2c_state_t           r_state;
    logic [BIT_CNT_W-1:0] r_bit_cnt;
    logic [7:0]           r_shift;
    logic                 r_rw;
    logic                 r_ptr_loaded;
    logic                 r_ack_drv;   // ACK slot entered: next fall ends it
    logic                 r_load;      // cycle after reg_re: rdata is valid

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clk     (clk),
        .reset_n (reset_n),
        .line_i  (scl_i),
        .level   (w_scl_level),
        .rise    (w_scl_rise),
        .fall    (w_scl_fall)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clk     (clk),
        .reset_n (reset_n),
        .line_i  (sda_i),
        .level   (w_sda_level),
        .rise    (w_sda_rise),
        .fall    (w_sda_fall)
    );

    assign w_start = w_sda_fall & w_scl_level;
    assign w_stop  = w_sda_rise & w_scl_level;
    // Byte as it stands once the current rise's bit is shifted in.
    assign w_byte  = {r_shift[6:0], w_sda_level};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_rw         <= 1'b0;
            r_ptr_loaded <= 1'b0;
            r_ack_drv    <= 1'b0;
            r_load       <= 1'b0;
            sda_oe       <= 1'b0;
            reg_addr     <= '0;
            reg_wdata    <= '0;
            reg_we       <= 1'b0;
            reg_re       <= 1'b0;
            addressed    <= 1'b0;
        end else begin
            reg_we <= 1'b0;
            reg_re <= 1'b0;
            r_load <= reg_re;

            // Post-access pointer advance; these never coincide with a bus
            // edge that touches the same registers.
            if (reg_we) begin
                reg_addr <= reg_addr + 8'd1;
            end
            if (r_load) begin
                r_shift  <= reg_rdata;
                reg_addr <= reg_addr + 8'd1;
            end

            if (w_start) begin
                r_state      <= ADDR;
                r_bit_cnt    <= '0;
                r_ptr_loaded <= 1'b0;
                r_ack_drv    <= 1'b0;
                sda_oe       <= 1'b0;
                addressed    <= 1'b0;
            end else if (w_stop) begin
                r_state   <= IDLE;
                r_ack_drv <= 1'b0;
                sda_oe    <= 1'b0;
                addressed <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: ;
                    ADDR: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_byte;
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            if (r_bit_cnt == c_last_bit) begin
                                r_rw <= w_sda_level;
                                // r_shift[6:0] holds the 7 address bits here.
                                if (r_shift[6:0] == TARGET_ADDR) begin
                                    r_state   <= ADDR_ACK;
                                    r_ack_drv <= 1'b0;
                                end else begin
                                    r_state <= IDLE;
                                end
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_ack_drv) begin
                                sda_oe    <= 1'b1;
                                addressed <= 1'b1;
                                r_ack_drv <= 1'b1;
                            end else begin
                                r_ack_drv <= 1'b0;
                                if (r_rw) begin
                                    // Read byte 0 was loaded during the ACK
                                    // high phase; its MSB goes out right now.
                                    r_state   <= RD_BYTE;
                                    sda_oe    <= ~r_shift[7];
                                    r_shift   <= {r_shift[6:0], 1'b0};
                                    r_bit_cnt <= BIT_CNT_W'(1);
                                end else begin
                                    r_state   <= WR_BYTE;
                                    sda_oe    <= 1'b0;
                                    r_bit_cnt <= '0;
                                end
                            end
                        end else if (w_scl_rise && r_ack_drv && r_rw) begin
                            reg_re <= 1'b1;
                        end
                    end
                    WR_BYTE: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_byte;
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            if (r_bit_cnt == c_last_bit) begin
                                if (!r_ptr_loaded) begin
                                    reg_addr     <= w_byte;
                                    r_ptr_loaded <= 1'b1;
                                end else begin
                                    reg_wdata <= w_byte;
                                    reg_we    <= 1'b1;
                                end
                                r_state   <= WR_ACK;
                                r_ack_drv <= 1'b0;
                            end
                        end
                    end
                    WR_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_ack_drv) begin
                                sda_oe    <= 1'b1;
                                r_ack_drv <= 1'b1;
                            end else begin
                                sda_oe    <= 1'b0;
                                r_ack_drv <= 1'b0;
                                r_state   <= WR_BYTE;
                                r_bit_cnt <= '0;
                            end
                        end
                    end
                    RD_BYTE: begin
                        if (w_scl_fall) begin
                            if (r_bit_cnt == c_byte_done) begin
                                sda_oe  <= 1'b0;
                                r_state <= RD_ACK;
                            end else begin
                                sda_oe    <= ~r_shift[7];
                                r_shift   <= {r_shift[6:0], 1'b0};
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end
                    end
                    RD_ACK: begin
                        if (w_scl_rise) begin
                            if (!w_sda_level) begin
                                reg_re    <= 1'b1;
                                r_state   <= RD_BYTE;
                                r_bit_cnt <= '0;
                            end else begin
                                r_state <= WAIT;
                            end
                        end
                    end
                    WAIT: ;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule : i2c_target
`default_nettype wire

// File: tb/tb_i2c_target.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_target
// Description : Self-checking bench for i2c_target. A bus controller model
//               drives SCL/SDA; a pointer/register model predicts register
//               strobes, read data (rdata = addr ^ 0x5A) and ACKs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_target;
    import i2c_pkg::*;

    localparam int Q = 10;   // quarter-ish phase in clks
    localparam int H = 20;   // SCL high time in clks

    logic       clk = 1'b0;
    logic       reset_n;
    logic       m_scl;
    logic       m_sda;
    logic       scl_i;
    logic       sda_i;
    logic       sda_oe;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata = 8'h00;
    logic       addressed;

    assign scl_i = m_scl;
    assign sda_i = m_sda & ~sda_oe;   // wired-AND open-drain bus

    i2c_target #(.TARGET_ADDR(7'h60), .FILTER_LEN(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .sda_oe    (sda_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .addressed (addressed)
    );

    always #5 clk = ~clk;

    // Register file: data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (reg_re) reg_rdata <= reg_addr ^ 8'h5A;
    end

    // Strobe / bus monitor
    logic [15:0] we_q[$];
    logic [7:0]  re_q[$];
    int          oe_cnt      = 0;
    int          overlap_cnt = 0;
    int          wide_cnt    = 0;
    int          addr_cnt    = 0;
    logic        prev_we     = 1'b0;
    logic        prev_re     = 1'b0;

    always @(negedge clk) begin
        if (reg_we) we_q.push_back({reg_addr, reg_wdata});
        if (reg_re) re_q.push_back(reg_addr);
        if (reg_we && reg_re) overlap_cnt <= overlap_cnt + 1;
        if ((reg_we && prev_we) || (reg_re && prev_re)) wide_cnt <= wide_cnt + 1;
        if (sda_oe) oe_cnt <= oe_cnt + 1;
        if (dut.r_state == ADDR) addr_cnt <= addr_cnt + 1;
        prev_we <= reg_we;
        prev_re <= reg_re;
    end

    int         total = 0;
    int         bad   = 0;
    logic [7:0] mptr  = 8'h00;   // model of the register pointer

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_xfer(input logic b, output logic r);
        m_sda = b;
        wc(Q);
        m_scl = 1'b1;
        wc(H);
        r = sda_i;
        m_scl = 1'b0;
        wc(Q);
    endtask

    task automatic start_c();
        if (!m_scl) begin
            m_sda = 1'b1;
            wc(Q);
            m_scl = 1'b1;
            wc(Q);
        end
        m_sda = 1'b0;
        wc(Q);
        m_scl = 1'b0;
        wc(Q);
    endtask

    task automatic stop_c();
        m_sda = 1'b0;
        wc(Q);
        m_scl = 1'b1;
        wc(Q);
        m_sda = 1'b1;
        wc(2 * Q);
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
        bit_xfer(1'b1, r);
        ack = ~r;
    endtask

    task automatic rd_byte(input logic mack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, r);
            d[i] = r;
        end
        bit_xfer(~mack, r);
    endtask

    // Write transaction: pointer byte then n data bytes (dat[7:0] first).
    task automatic do_write(input logic [6:0] a, input logic [7:0] p, input logic [23:0] dat,
                            input int n, input logic exp_ack, input int exp_we);
        int          w0, r0, o0;
        logic        ack;
        logic [7:0]  b;
        logic [15:0] e[$];
        w0 = we_q.size();
        r0 = re_q.size();
        o0 = oe_cnt;
        start_c();
        wr_byte({a, 1'b0}, ack);
        chk("addr_ack", ack, exp_ack);
        chk("addressed_on", addressed, exp_ack);
        wr_byte(p, ack);
        chk("ptr_ack", ack, exp_ack);
        if (a == 7'h60) begin
            mptr = p;
            for (int i = 0; i < n; i++) begin
                b = dat[8*i +: 8];
                wr_byte(b, ack);
                chk("data_ack", ack, 1);
                e.push_back({mptr, b});
                mptr = mptr + 8'd1;
            end
        end else begin
            chk("nak_oe_cnt", oe_cnt - o0, 0);
            chk("nak_re_cnt", re_q.size() - r0, 0);
        end
        stop_c();
        chk("addressed_off", addressed, 0);
        chk("we_count", we_q.size() - w0, exp_we);
        for (int i = 0; i < e.size(); i++)
            chk("we_entry", (w0 + i < we_q.size()) ? {16'h0, we_q[w0 + i]} : 32'hDEAD_BEEF, {16'h0, e[i]});
        chk("ptr_after_wr", reg_addr, mptr);
    endtask

    // Read transaction: optional pointer set + repeated START, n bytes, NACK last.
    task automatic do_read(input int n, input logic set_ptr, input logic [7:0] p);
        int         r0;
        logic       ack;
        logic [7:0] d;
        r0 = re_q.size();
        start_c();
        if (set_ptr) begin
            wr_byte(8'hC0, ack);
            chk("rd_waddr_ack", ack, 1);
            wr_byte(p, ack);
            chk("rd_ptr_ack", ack, 1);
            mptr = p;
            start_c();
        end
        wr_byte(8'hC1, ack);
        chk("rd_addr_ack", ack, 1);
        chk("rd_addressed", addressed, 1);
        for (int i = 0; i < n; i++) begin
            rd_byte(i != n - 1, d);
            chk("rd_data", d, mptr ^ 8'h5A);
            chk("re_addr", (r0 + i < re_q.size()) ? {24'h0, re_q[r0 + i]} : 32'hDEAD_BEEF, {24'h0, mptr});
            mptr = mptr + 8'd1;
        end
        wc(5);
        chk("oe_after_nack", sda_oe, 0);
        stop_c();
        chk("re_count", re_q.size() - r0, n);
        chk("ptr_after_rd", reg_addr, mptr);
        chk("rd_addressed_off", addressed, 0);
    endtask

    typedef struct {
        logic [6:0]  addr;
        logic [7:0]  ptr;
        logic [23:0] dat;
        int          n;
        logic        exp_ack;
        int          exp_we;
    } wvec_t;

    wvec_t tbl[4];

    initial begin
        logic got;
        logic ack;
        int   a0;
        int   o0;

        tbl[0] = '{7'h60, 8'h10, 24'h00CDAB, 2, 1'b1, 2};
        tbl[1] = '{7'h50, 8'h10, 24'h000000, 0, 1'b0, 0};
        tbl[2] = '{7'h60, 8'hFF, 24'h030201, 3, 1'b1, 3};
        tbl[3] = '{7'h60, 8'h40, 24'h000000, 0, 1'b1, 0};

        reset_n = 1'b0;
        m_scl   = 1'b1;
        m_sda   = 1'b1;
        wc(3);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_strobes", {reg_we, reg_re}, 0);
        chk("rst_addressed", addressed, 0);
        chk("rst_regs", {reg_addr, reg_wdata}, 0);
        reset_n = 1'b1;
        wc(20);

        // Table-driven write transactions
        for (int i = 0; i < 4; i++)
            do_write(tbl[i].addr, tbl[i].ptr, tbl[i].dat, tbl[i].n, tbl[i].exp_ack, tbl[i].exp_we);

        // Pointer set then read two bytes: ACK then NACK
        do_read(2, 1'b1, 8'h20);

        // Glitch rejection on SDA while SCL is high
        a0 = addr_cnt;
        m_sda = 1'b0;
        wc(2);
        m_sda = 1'b1;
        wc(20);
        chk("glitch_no_start", addr_cnt - a0, 0);
        a0 = addr_cnt;
        m_sda = 1'b0;
        wc(6);
        m_sda = 1'b1;
        wc(20);
        chk("pulse_start_seen", (addr_cnt - a0) > 0, 1);
        chk("pulse_then_idle", dut.r_state, IDLE);

        // Reset while the target is driving a read bit
        start_c();
        wr_byte(8'hC0, ack);
        wr_byte(8'h20, ack);
        start_c();
        wr_byte(8'hC1, ack);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (sda_oe) got = 1'b1;
        end
        chk("oe_before_reset", got, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_oe", sda_oe, 0);
        chk("async_rst_addressed", addressed, 0);
        chk("async_rst_ptr", reg_addr, 0);
        m_scl = 1'b1;
        m_sda = 1'b1;
        wc(3);
        reset_n = 1'b1;
        wc(20);
        mptr = 8'h00;
        do_write(7'h60, 8'h33, 24'h000044, 1, 1'b1, 1);

        // Pointer persists across transactions: read without setting it
        do_read(1, 1'b0, 8'h00);

        // Randomised transactions against the pointer model
        for (int k = 0; k < 10; k++) begin
            int          kind;
            int          n;
            logic [6:0]  a;
            logic [23:0] dat;
            logic [7:0]  p;
            kind = $urandom_range(0, 2);
            p    = 8'($urandom);
            dat  = 24'($urandom);
            if (kind == 0) begin
                n = $urandom_range(0, 3);
                do_write(7'h60, p, dat, n, 1'b1, n);
            end else if (kind == 1) begin
                n = $urandom_range(1, 3);
                do_read(n, 1'($urandom_range(0, 1)), p);
            end else begin
                a = 7'($urandom_range(0, 127));
                if (a == 7'h60) a = 7'h61;
                o0 = oe_cnt;
                do_write(a, p, dat, 2, 1'b0, 0);
                chk("rand_nak_oe", oe_cnt - o0, 0);
            end
        end

        chk("strobe_overlap", overlap_cnt, 0);
        chk("strobe_width", wide_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_i2c_target
`default_nettype wire

// File: doc/i2c_target.md
Name: i2c_target

Overview:
I2C target (responder) for the board's 400 kHz two-wire bus. It complements the existing write-only I2C initiator, so an external controller or a loopback bench can reach an 8-bit register space inside the SoC. Standard-mode and fast-mode only. No clock stretching, no high-speed mode. It sits between the open-drain pads and a simple single-cycle register port.

Parameters:
TARGET_ADDR, 7'h60, 7-bit address this block answers to
FILTER_LEN, 4, clk cycles a synchronised line level must hold before the filtered level changes (max 15)

Ports:
clk  in  1  system clock (48 MHz nominal)
reset_n  in  1  asynchronous, active-low reset
scl_i  in  1  raw SCL pad level
sda_i  in  1  raw SDA pad level
sda_oe  out  1  1 = pull SDA low; pad is open-drain
reg_addr  out  8  register pointer
reg_wdata  out  8  write data
reg_we  out  1  one-cycle write strobe
reg_re  out  1  one-cycle read strobe
reg_rdata  in  8  read data, valid the clk cycle after reg_re
addressed  out  1  high from address ACK until STOP or START

Behaviour:
- Reset: one clk; reset is asynchronous and active-low (reset_n).
- On reset assertion, immediately: sda_oe=0, reg_we=0, reg_re=0, addressed=0, reg_addr=0, reg_wdata=0, state IDLE, filtered SCL and SDA = 1. Reset mid-byte releases SDA at once.
- Input conditioning (per line):
  - 2-flop synchroniser, then filter counter. The filtered level follows the synced level only after FILTER_LEN consecutive equal samples.
  - Rise and fall pulses, one clk each, come from the filtered level.
- Bus events:
  - START = SDA fall while SCL high.
  - STOP = SDA rise while SCL high.
  - Either event, in any state, releases sda_oe and clears addressed. START then goes to ADDR with bit count 0; STOP goes to IDLE. Repeated START is just START.
- Timing: sample SDA on the SCL rise pulse; change sda_oe only on the SCL fall pulse.
- FSM states and transitions:
  - IDLE -> ADDR only on START.
  - ADDR: shift 8 bits MSB first. After the 8th rise, compare [7:1] with TARGET_ADDR.
    - Mismatch -> IDLE; sda_oe stays 0.
    - Match -> ADDR_ACK: on the next SCL fall set sda_oe=1 and addressed=1.
  - ADDR_ACK: on the following SCL fall set sda_oe=0.
    - R/W=0 -> WR_BYTE. The first data byte after the address is the pointer (ptr_loaded=0).
    - R/W=1 -> RD_BYTE with the load sequence below.
  - WR_BYTE: after the 8th rise, branch on ptr_loaded.
    - ptr_loaded=0: reg_addr <= byte, ptr_loaded <= 1.
    - ptr_loaded=1: reg_wdata <= byte, then reg_we pulses for one clk in the next cycle with the current reg_addr. reg_addr increments (mod 256) the cycle after reg_we.
    - Then WR_ACK: sda_oe=1 from the next SCL fall until the fall after it, then back to WR_BYTE.
  - Read load: reg_re pulses one clk with reg_addr. On the next clk, capture reg_rdata into the shift register and increment reg_addr (mod 256).
    - Read byte 0: load at the ADDR_ACK rise, data bit 7 driven at the ADDR_ACK-ending fall.
    - Later bytes: load at the RD_ACK rise when master ACK=0.
  - RD_BYTE: on each SCL fall, sda_oe = ~shift[7], then shift left. After the 8th bit, the next fall releases sda_oe -> RD_ACK.
  - RD_ACK: sample SDA at the rise.
    - 0 (ACK) -> reload, RD_BYTE.
    - 1 (NACK) -> WAIT, sda_oe=0, until START or STOP.
- Pointer: persists across transactions (not cleared by STOP); cleared only by reset. ptr_loaded clears on every START.
- Strobes: reg_we and reg_re never assert in the same clk and are never more than one clk wide.
- Latency: with FILTER_LEN=4 and 48 MHz, a pad edge reaches the FSM 6–7 clk later. This is well inside the 400 kHz setup/hold margins.

Decomposition:
- Package i2c_pkg holds:
  - the state enum (IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT);
  - localparams for bit count width and the filter counter width.
- One sub-module, i2c_line_filter, instantiated for SCL and SDA. It contains the synchroniser, filter counter, filtered level, and rise/fall pulses, with an asynchronous active-low reset to level 1.

Test Plan:
- Write START,0xC0,0x10,0xAB,0xCD,STOP -> ACK on all 4 bytes. reg_we at (0x10,0xAB) then (0x11,0xCD). addressed falls at STOP.
- Wrong address START,0xA0,0x10,STOP -> sda_oe never 1, no reg_we/reg_re, addressed stays 0.
- START,0xC0,0x20, repeated START,0xC1, read 2 bytes; bench reg_rdata = addr^0x5A; master ACK then NACK -> bytes 0x7A,0x7B. reg_re at 0x20 and 0x21, sda_oe=0 after NACK, reg_addr=0x22.
- Pointer wrap: write ptr 0xFF, then data 0x01,0x02,0x03 -> reg_we addresses 0xFF,0x00,0x01.
- Glitch: while SCL high, a 2-clk SDA low pulse (< FILTER_LEN) -> no START/STOP, FSM stays IDLE. A 6-clk pulse -> START, then STOP.
- Drop reset_n mid read bit while sda_oe=1 -> sda_oe=0 in the same cycle, addressed=0, reg_addr=0. A subsequent full write transaction succeeds.
